// File: rtl/clock_cal_seq.sv
`default_nettype none
// ============================================================================
//  Module   : clock_cal_seq
//  Purpose  : Calibration sequencer for the CLOCK generator. Latches a
//             request, pulses CLOCK resetn, waits for lock/fail and retries
//             with a stepped trim until lock, trim overflow, retry limit or
//             timeout.
//  Revision : 1.0  initial release
// ============================================================================
module clock_cal_seq #(
    parameter int RST_CYCLES = 100,
    parameter int TIMEOUT    = 1000000,
    parameter int INIT_STEP  = 4,
    parameter int MAX_TRIES  = 8
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] req_target,
    input  logic [31:0] req_ref,
    input  logic [8:0]  req_init,
    output logic        clk_resetn,
    output logic [31:0] clk_counter,
    output logic [31:0] clk_ref_counter,
    output logic [8:0]  clk_init,
    input  logic [2:0]  clk_status,
    output logic        busy,
    output logic        done,
    output logic        locked,
    output logic [1:0]  err_code,
    output logic [7:0]  tries,
    output logic [8:0]  lock_init
);

    // One timer serves both the reset-hold phase and the run timeout.
    localparam int c_TIMER_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);

    localparam logic [c_TIMER_W-1:0] c_HOLD_LAST = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_RUN_LAST  = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
    localparam logic [9:0]           c_STEP      = 10'(INIT_STEP);
    localparam logic [7:0]           c_MAX_TRIES = 8'(MAX_TRIES);

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_RETRIES = 2'd1;
    localparam logic [1:0] c_ERR_TRIM    = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt;
    logic [31:0]            r_target, w_target_nxt;
    logic [31:0]            r_ref, w_ref_nxt;
    logic [8:0]             r_init, w_init_nxt;
    logic [7:0]             r_tries, w_tries_nxt;
    logic                   r_locked, w_locked_nxt;
    logic [1:0]             r_err, w_err_nxt;
    logic [8:0]             r_lock_init, w_lock_init_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_clk_resetn, w_resetn_nxt;

    logic [9:0]             w_trim_sum;
    logic                   w_abortable;
    logic                   w_status_unused;

    // status[0] carries no meaning for calibration.
    assign w_status_unused = clk_status[0];

    // Ten-bit sum so a step past 511 is visible as overflow.
    assign w_trim_sum  = {1'b0, r_init} + c_STEP;
    assign w_abortable = (r_state == S_HOLD) || (r_state == S_RUN) || (r_state == S_STEP);

    // State and datapath registers.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_target     <= '0;
            r_ref        <= '0;
            r_init       <= '0;
            r_tries      <= '0;
            r_locked     <= 1'b0;
            r_err        <= c_ERR_NONE;
            r_lock_init  <= '0;
            r_busy       <= 1'b0;
            r_clk_resetn <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_target     <= w_target_nxt;
            r_ref        <= w_ref_nxt;
            r_init       <= w_init_nxt;
            r_tries      <= w_tries_nxt;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
            r_lock_init  <= w_lock_init_nxt;
            r_busy       <= w_busy_nxt;
            r_clk_resetn <= w_resetn_nxt;
        end
    end

    // Next-state and next-value logic; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_target_nxt    = r_target;
        w_ref_nxt       = r_ref;
        w_init_nxt      = r_init;
        w_tries_nxt     = r_tries;
        w_locked_nxt    = r_locked;
        w_err_nxt       = r_err;
        w_lock_init_nxt = r_lock_init;
        w_busy_nxt      = r_busy;
        w_resetn_nxt    = r_clk_resetn;

        if (w_abortable && abort) begin
            // Abandon silently: CLOCK held in reset, results untouched.
            w_state_nxt  = S_IDLE;
            w_timer_nxt  = '0;
            w_busy_nxt   = 1'b0;
            w_resetn_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A CLOCK left locked by the last request keeps running here.
                    if (start) begin
                        w_target_nxt = req_target;
                        w_ref_nxt    = req_ref;
                        w_init_nxt   = req_init;
                        w_tries_nxt  = 8'd1;
                        w_locked_nxt = 1'b0;
                        w_err_nxt    = c_ERR_NONE;
                        w_busy_nxt   = 1'b1;
                        w_resetn_nxt = 1'b0;
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    w_resetn_nxt = 1'b0;
                    if (r_timer == c_HOLD_LAST) begin
                        w_timer_nxt  = '0;
                        w_resetn_nxt = 1'b1;
                        w_state_nxt  = S_RUN;
                    end else begin
                        w_timer_nxt = r_timer + c_TIMER_ONE;
                    end
                end
                S_RUN: begin
                    // Fail has priority over lock when both are reported.
                    if (clk_status[2]) begin
                        w_resetn_nxt = 1'b0;
                        w_state_nxt  = S_STEP;
                    end else if (clk_status[1]) begin
                        w_lock_init_nxt = r_init;
                        w_locked_nxt    = 1'b1;
                        w_state_nxt     = S_FINISH;
                    end else if (r_timer == c_RUN_LAST) begin
                        w_err_nxt    = c_ERR_TIMEOUT;
                        w_resetn_nxt = 1'b0;
                        w_state_nxt  = S_FINISH;
                    end else begin
                        w_timer_nxt = r_timer + c_TIMER_ONE;
                    end
                end
                S_STEP: begin
                    // Retry limit is checked before trim overflow.
                    if (r_tries == c_MAX_TRIES) begin
                        w_err_nxt   = c_ERR_RETRIES;
                        w_state_nxt = S_FINISH;
                    end else if (w_trim_sum[9]) begin
                        w_err_nxt   = c_ERR_TRIM;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_init_nxt  = w_trim_sum[8:0];
                        w_tries_nxt = r_tries + 8'd1;
                        w_timer_nxt = '0;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_FINISH: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_busy_nxt   = 1'b0;
                    w_resetn_nxt = 1'b0;
                end
            endcase
        end
    end

    assign clk_resetn      = r_clk_resetn;
    assign clk_counter     = r_target;
    assign clk_ref_counter = r_ref;
    assign clk_init        = r_init;
    assign busy            = r_busy;
    assign done            = (r_state == S_FINISH);
    assign locked          = r_locked;
    assign err_code        = r_err;
    assign tries           = r_tries;
    assign lock_init       = r_lock_init;

endmodule
`default_nettype wire

// File: tb/tb_clock_cal_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_cal_seq
//  Purpose  : Scoreboard bench for clock_cal_seq with a behavioural CLOCK
//             stub and an attempt-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_cal_seq;

    localparam int R    = 5;
    localparam int T    = 1000;
    localparam int STEP = 4;
    localparam int MAXT = 8;

    logic        ref_clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [31:0] req_target, req_ref;
    logic [8:0]  req_init;
    logic        clk_resetn;
    logic [31:0] clk_counter, clk_ref_counter;
    logic [8:0]  clk_init;
    logic [2:0]  clk_status;
    logic        busy, done, locked;
    logic [1:0]  err_code;
    logic [7:0]  tries;
    logic [8:0]  lock_init;

    clock_cal_seq #(
        .RST_CYCLES (R),
        .TIMEOUT    (T),
        .INIT_STEP  (STEP),
        .MAX_TRIES  (MAXT)
    ) dut (
        .ref_clk         (ref_clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .req_target      (req_target),
        .req_ref         (req_ref),
        .req_init        (req_init),
        .clk_resetn      (clk_resetn),
        .clk_counter     (clk_counter),
        .clk_ref_counter (clk_ref_counter),
        .clk_init        (clk_init),
        .clk_status      (clk_status),
        .busy            (busy),
        .done            (done),
        .locked          (locked),
        .err_code        (err_code),
        .tries           (tries),
        .lock_init       (lock_init)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct packed {
        logic [8:0]  trim;
        logic [31:0] tgt;
        logic [31:0] rf;
    } att_t;

    typedef struct packed {
        logic [1:0]  err;
        logic        lck;
        logic [7:0]  tr;
        logic [8:0]  li;
        int unsigned dcyc;
    } res_t;

    att_t        tq[$];
    res_t        rq[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [8:0]  mdl_li = '0;

    // CLOCK stub configuration: pair is {fail, lock}.
    int          cfg_nfail = 0;
    logic [1:0]  cfg_pre   = 2'b10;
    logic [1:0]  cfg_fin   = 2'b01;
    int          cfg_delay = 0;

    int          cnt, att, st_idx;
    logic        stub_prev;
    logic [2:0]  noise;
    logic [1:0]  st_pair;
    logic        mon_prev = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge ref_clk) cyc <= cyc + 1;

    // CLOCK stub: counts cycles since resetn rose and reports per-attempt outcome.
    always @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            cnt <= 0; att <= 0; stub_prev <= 1'b0; noise <= '0;
        end else begin
            noise     <= 3'($urandom);
            stub_prev <= clk_resetn;
            cnt       <= clk_resetn ? cnt + 1 : 0;
            if (start && !busy)              att <= 0;
            else if (clk_resetn && !stub_prev) att <= att + 1;
        end
    end

    always_comb begin
        st_idx     = att + ((clk_resetn && !stub_prev) ? 1 : 0) - 1;
        st_pair    = (st_idx < cfg_nfail) ? cfg_pre : cfg_fin;
        clk_status = noise;
        if (clk_resetn)
            clk_status = (cnt >= cfg_delay) ? {st_pair, noise[0]} : {2'b00, noise[0]};
    end

    // Monitor: checks each resetn rise against the attempt queue, each done against results.
    always @(negedge ref_clk) begin
        att_t a;
        res_t r;
        if (!reset) begin
            if (clk_resetn && !mon_prev) begin
                if (tq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL attempt: unexpected clk_resetn rise, clk_init=%0d", clk_init);
                end else begin
                    a = tq.pop_front();
                    check("attempt_trim", 64'(clk_init), 64'(a.trim));
                    check("attempt_buses", {clk_counter, clk_ref_counter}, {a.tgt, a.rf});
                end
            end
            if (done) begin
                if (rq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL done: unexpected pulse, err_code=%0d", err_code);
                end else begin
                    r = rq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(r.dcyc));
                    check("err_code", 64'(err_code), 64'(r.err));
                    check("locked", 64'(locked), 64'(r.lck));
                    check("tries", 64'(tries), 64'(r.tr));
                    check("lock_init", 64'(lock_init), 64'(r.li));
                    check("finish_resetn", 64'(clk_resetn), 64'(r.lck));
                end
            end
        end
        mon_prev = clk_resetn;
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 30000 && !ok; n++) begin
            @(posedge ref_clk); #1;
            start = 1'b0;
            if (!busy) ok = 1'b1;
            else begin
                if ($urandom_range(0, 5) == 0) start = 1'b1;
                req_target = $urandom;
                req_ref    = $urandom;
                req_init   = 9'($urandom);
            end
        end
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL wait_idle: busy=%0b after 30000 cycles, required 0", busy);
        end
    endtask

    // Reference model walks attempts: trim = init + STEP*i, timing from phase lengths.
    task automatic run_req(input int init, input logic [31:0] tgt, input logic [31:0] rf,
                           input int nfail, input logic [1:0] pre, input logic [1:0] fin,
                           input int d, input logic abw);
        int h, trim, endc;
        res_t r;
        att_t a;
        logic [1:0] pr;
        cfg_nfail = nfail; cfg_pre = pre; cfg_fin = fin; cfg_delay = d;
        r = '0;
        h = int'(cyc) + 1;
        for (int i = 0; i < 256; i++) begin
            trim   = init + STEP * i;
            a.trim = 9'(trim); a.tgt = tgt; a.rf = rf;
            tq.push_back(a);
            r.tr = 8'(i + 1);
            pr   = (i < nfail) ? pre : fin;
            if (pr[1]) begin
                endc = h + R + d;
                if (i + 1 == MAXT)     begin r.err = 2'd1; r.dcyc = endc + 2; break; end
                if (trim + STEP > 511) begin r.err = 2'd2; r.dcyc = endc + 2; break; end
                h = endc + 2;
            end else if (pr[0]) begin
                r.lck  = 1'b1;
                mdl_li = 9'(trim);
                r.dcyc = h + R + d + 1;
                break;
            end else begin
                r.err  = 2'd3;
                r.dcyc = h + R + T;
                break;
            end
        end
        r.li = mdl_li;
        rq.push_back(r);
        req_target = tgt; req_ref = rf; req_init = 9'(init);
        start = 1'b1; abort = abw;
        @(posedge ref_clk); #1;
        start = 1'b0; abort = 1'b0;
        req_target = $urandom; req_ref = $urandom; req_init = 9'($urandom);
        wait_idle();
    endtask

    initial begin
        att_t a;
        bit   seen;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        req_target = '0; req_ref = '0; req_init = '0;
        repeat (3) @(posedge ref_clk); #1;
        check("rst_ctrl", {busy, done, locked, clk_resetn}, 4'b0000);
        check("rst_err_tries", {err_code, tries}, 10'd0);
        check("rst_lock_init", 64'(lock_init), 64'd0);
        check("rst_buses", {clk_counter, clk_ref_counter}, 64'd0);
        reset = 1'b0;
        @(posedge ref_clk); #1;
        abort = 1'b1;
        @(posedge ref_clk); #1;
        abort = 1'b0;
        check("idle_abort_ignored", {busy, done}, 2'b00);

        // Directed scenarios.
        run_req(20, 32'd5000, 32'd10, 0, 2'b10, 2'b01, 50, 1'b0);
        check("idle_resetn_locked", 64'(clk_resetn), 64'd1);
        run_req(20, 32'd5000, 32'd10, 2, 2'b10, 2'b01, 7, 1'b0);
        run_req(500, 32'd777, 32'd3, 0, 2'b10, 2'b10, 3, 1'b0);
        run_req(0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 2'b10, 2'b10, 1, 1'b0);
        run_req(100, 32'd42, 32'd43, 0, 2'b10, 2'b00, 0, 1'b0);
        run_req(40, 32'd9, 32'd8, 2, 2'b11, 2'b01, 0, 1'b1);

        // Abort mid-RUN, then a new request on the very next cycle.
        cfg_nfail = 0; cfg_fin = 2'b00; cfg_delay = 0;
        a.trim = 9'd77; a.tgt = 32'h1234; a.rf = 32'h55;
        tq.push_back(a);
        req_target = 32'h1234; req_ref = 32'h55; req_init = 9'd77;
        start = 1'b1;
        @(posedge ref_clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge ref_clk); #1;
            if (clk_resetn) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++; n_err++;
            $display("FAIL abort_setup: clk_resetn stayed 0, required rise");
        end
        repeat (10) @(posedge ref_clk);
        #1 abort = 1'b1;
        @(posedge ref_clk); #1;
        abort = 1'b0;
        check("abort_busy_resetn", {busy, clk_resetn, done}, 3'b000);
        check("abort_results", {locked, err_code, tries}, {1'b0, 2'd0, 8'd1});
        run_req(300, 32'd11, 32'd12, 1, 2'b10, 2'b01, 20, 1'b0);

        // Reset in the middle of HOLD.
        cfg_fin = 2'b01;
        req_target = 32'hA5A5_0001; req_ref = 32'h5A5A; req_init = 9'h033;
        start = 1'b1;
        @(posedge ref_clk); #1;
        start = 1'b0;
        @(posedge ref_clk); #2;
        reset = 1'b1;
        #1;
        check("midhold_rst_ctrl", {busy, done, locked, clk_resetn}, 4'b0000);
        check("midhold_rst_results", {err_code, tries, lock_init}, 19'd0);
        check("midhold_rst_buses", {clk_counter, clk_ref_counter, 23'd0, clk_init}, 96'd0);
        @(posedge ref_clk); #1;
        reset = 1'b0;
        mdl_li = '0;
        @(posedge ref_clk); #1;

        // Randomised requests.
        for (int k = 0; k < 20; k++) begin
            logic [1:0] fin;
            case ($urandom_range(0, 7))
                0:       fin = 2'b00;
                1, 2:    fin = 2'b10;
                3:       fin = 2'b11;
                default: fin = 2'b01;
            endcase
            run_req(int'($urandom_range(0, 511)), $urandom, $urandom,
                    int'($urandom_range(0, 9)), $urandom_range(0, 1) ? 2'b11 : 2'b10,
                    fin, int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge ref_clk); #1;
        check("results_drained", 64'(rq.size()), 64'd0);
        check("attempts_drained", 64'(tq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
